serv_rf_ram_arb: RTL
====================

# serv_rf_ram_arb

Port arbiter and initialiser for the register-file SRAM behind the SERV RF RAM interface. It has three jobs:
- After reset, it clears every word of the SRAM to zero.
- It then passes the RF interface's fixed-schedule accesses straight through. These have absolute priority and are never stalled.
- It slots single-word debug/loader reads and writes into SRAM port cycles that the RF interface leaves idle.

It sits between the RF RAM interface, an external debug requester and the physical 1R1W SRAM.

## Interface
Parameters:
- width, 8: SRAM data width.
- csr_regs, 4: CSR registers allocated after the 32 GPRs.
- init_ram, 1: 1 clears the SRAM after reset; 0 starts directly in IDLE.
- raw, $clog2(32+csr_regs): internal, do not override.
- l2w, $clog2(width): internal, do not override.
- aw, 5+raw-l2w: internal, do not override. SRAM address width; depth is 2**aw.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset. Asynchronous, active-high.
- i_rf_waddr  in  aw  RF write address.
- i_rf_wdata  in  width  RF write data.
- i_rf_wen  in  1  RF write enable.
- i_rf_raddr  in  aw  RF read address.
- i_rf_ren  in  1  RF read enable.
- o_rf_rdata  out  width  RF read data (equals i_rdata).
- i_dbg_req  in  1  debug request; held high until o_dbg_ack.
- i_dbg_we  in  1  1 = write, 0 = read. Stable while i_dbg_req is high.
- i_dbg_addr  in  aw  debug word address. Stable while i_dbg_req is high.
- i_dbg_wdata  in  width  debug write data. Stable while i_dbg_req is high.
- o_dbg_ack  out  1  one-cycle completion pulse.
- o_dbg_rdata  out  width  debug read data; valid while o_dbg_ack is high, then held.
- o_init_done  out  1  high once clearing is finished; core is held in reset until then.
- o_waddr  out  aw  SRAM write address.
- o_wdata  out  width  SRAM write data.
- o_wen  out  1  SRAM write enable.
- o_raddr  out  aw  SRAM read address.
- o_ren  out  1  SRAM read enable.
- i_rdata  in  width  SRAM read data; one-cycle read latency.

## Operation
- States:
  - INIT: clear the SRAM.
  - IDLE: pass RF traffic; accept a debug request when its port is free.
  - WR_ACK: acknowledge a granted debug write.
  - RD_WAIT: wait for the SRAM read data.
  - RD_ACK: acknowledge a granted debug read.
- Reset (asynchronous) state:
  - State is INIT (IDLE if init_ram=0).
  - Clear counter is 0.
  - o_init_done is 0 (1 if init_ram=0).
  - o_dbg_ack is 0.
  - o_dbg_rdata is 0.
- INIT:
  - Outputs: o_wen=1, o_waddr=counter, o_wdata=0, o_ren=0.
  - Counter increments each cycle, wrapping from 2**aw-1 to 0.
  - On the write of address 2**aw-1: go to IDLE and set o_init_done.
  - RF and debug inputs are ignored during INIT. A pending debug request waits.
- Write port, outside INIT:
  - If i_rf_wen=1: drive the RF address and data with o_wen=1.
  - Else if state is IDLE and i_dbg_req & i_dbg_we: drive the debug address and data with o_wen=1. This is the grant; go to WR_ACK.
  - Otherwise o_wen=0.
- Read port, outside INIT:
  - If i_rf_ren=1: o_raddr=i_rf_raddr, o_ren=1.
  - Else if state is IDLE and i_dbg_req & !i_dbg_we: o_raddr=i_dbg_addr, o_ren=1. This is the grant; go to RD_WAIT.
  - Otherwise o_ren=0.
- WR_ACK: o_dbg_ack=1 for one cycle, then go to IDLE.
- RD_WAIT: capture i_rdata into o_dbg_rdata, then go to RD_ACK.
- RD_ACK: o_dbg_ack=1 for one cycle, then go to IDLE.
- i_dbg_req is ignored in WR_ACK, RD_WAIT and RD_ACK. A new request is granted from IDLE no earlier than the cycle after the ack.
- RF accesses are never delayed or modified.
- A debug access is delayed indefinitely while its port is continuously used by RF. No starvation guard.
- A debug write and an RF read to the same address in the same cycle: read returns the old data (SRAM read-before-write).
- o_rf_rdata = i_rdata unconditionally.

## Timing
- Clearing takes 2**aw cycles (256 for defaults). Addresses 0..255 are written on the 1st..256th rising edges after reset release. o_init_done is high from the 256th edge onward.
- Debug write: grant in cycle G; o_dbg_ack in G+1. Latency from request is 1 cycle plus wait cycles.
- Debug read: grant in cycle G; i_rdata valid in G+1; o_dbg_rdata registered at the end of G+1; o_dbg_ack in G+2.
- o_dbg_ack and o_dbg_rdata are registered. SRAM address, data and enable outputs are combinational from state and inputs.
- Reset asserted mid-operation:
  - All registers return to reset values immediately.
  - An in-flight debug access is dropped with no ack.
  - Clearing restarts at address 0.

## Test plan
- Reset, then run 260 cycles, defaults -> addresses 0..255 each written once with 0; o_init_done rises after the 256th edge; no o_ren during INIT.
- After init: i_dbg_req=1, we=1, addr=0x23, wdata=0x5A, RF idle -> o_wen=1, o_waddr=0x23, o_wdata=0x5A that cycle; o_dbg_ack next cycle.
- Debug read addr=0x23 while i_rf_ren=1 for 3 cycles -> grant in the 4th cycle; o_dbg_ack 2 cycles later with o_dbg_rdata=0x5A.
- i_rf_wen=1 (addr 0x10, data 0xFF) in the same cycle as a debug write request -> RF write only; debug write issued on the first cycle with i_rf_wen=0.
- i_dbg_req asserted during INIT -> no SRAM access or ack until o_init_done=1; grant in the first IDLE cycle.
- i_rst pulsed in RD_WAIT -> no o_dbg_ack; o_init_done=0; clearing restarts at address 0.

Source files
------------

// File: rtl/serv_rf_ram_arb.sv
// serv_rf_ram_arb
//   Port arbiter and initialiser for the register-file SRAM (1R1W, 1-cycle read).
//   After reset it clears every SRAM word to zero. It then forwards RF interface
//   accesses unchanged, and fits single-word debug reads/writes into port cycles
//   that the RF leaves idle.
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_rf_*/o_rf_rdata     RF interface (fixed schedule, absolute priority)
//   i_dbg_*/o_dbg_*       debug requester (req held until the one-cycle ack)
//   o_init_done           high once the clear pass has finished
//   o_w*/o_r*/i_rdata     physical SRAM ports
module serv_rf_ram_arb #(
  parameter int width    = 8,
  parameter int csr_regs = 4,
  parameter int init_ram = 1,
  parameter int raw      = $clog2(32+csr_regs),
  parameter int l2w      = $clog2(width),
  parameter int aw       = 5+raw-l2w
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [aw-1:0]    i_rf_waddr,
  input  logic [width-1:0] i_rf_wdata,
  input  logic             i_rf_wen,
  input  logic [aw-1:0]    i_rf_raddr,
  input  logic             i_rf_ren,
  output logic [width-1:0] o_rf_rdata,
  input  logic             i_dbg_req,
  input  logic             i_dbg_we,
  input  logic [aw-1:0]    i_dbg_addr,
  input  logic [width-1:0] i_dbg_wdata,
  output logic             o_dbg_ack,
  output logic [width-1:0] o_dbg_rdata,
  output logic             o_init_done,
  output logic [aw-1:0]    o_waddr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic [aw-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [width-1:0] i_rdata
);

  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_WR_ACK  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RD_ACK  = 3'd4;

  localparam logic [2:0] S_RESET   = (init_ram != 0) ? S_INIT : S_IDLE;

  logic [2:0]       r_state;
  logic [aw-1:0]    r_cnt;
  logic             r_init_done;
  logic             r_dbg_ack;
  logic [width-1:0] r_dbg_rdata;

  logic w_wgrant;
  logic w_rgrant;

  assign o_rf_rdata  = i_rdata;
  assign o_init_done = r_init_done;
  assign o_dbg_ack   = r_dbg_ack;
  assign o_dbg_rdata = r_dbg_rdata;

  // Debug only gets a port the RF is not using this cycle, and only from IDLE.
  assign w_wgrant = (r_state == S_IDLE) && !i_rf_wen && i_dbg_req &&  i_dbg_we;
  assign w_rgrant = (r_state == S_IDLE) && !i_rf_ren && i_dbg_req && !i_dbg_we;

  always_comb begin
    o_waddr = '0;
    o_wdata = '0;
    o_wen   = 1'b0;
    o_raddr = '0;
    o_ren   = 1'b0;
    if (r_state == S_INIT) begin
      o_waddr = r_cnt;
      o_wen   = 1'b1;
    end else begin
      if (i_rf_wen) begin
        o_waddr = i_rf_waddr;
        o_wdata = i_rf_wdata;
        o_wen   = 1'b1;
      end else if (w_wgrant) begin
        o_waddr = i_dbg_addr;
        o_wdata = i_dbg_wdata;
        o_wen   = 1'b1;
      end
      if (i_rf_ren) begin
        o_raddr = i_rf_raddr;
        o_ren   = 1'b1;
      end else if (w_rgrant) begin
        o_raddr = i_dbg_addr;
        o_ren   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_RESET;
      r_cnt       <= '0;
      r_init_done <= (init_ram == 0);
      r_dbg_ack   <= 1'b0;
      r_dbg_rdata <= '0;
    end else begin
      // Ack is registered: it is high during WR_ACK and RD_ACK.
      r_dbg_ack <= w_wgrant || (r_state == S_RD_WAIT);
      case (r_state)
        S_INIT: begin
          r_cnt <= r_cnt + aw'(1);
          if (r_cnt == {aw{1'b1}}) begin
            r_state     <= S_IDLE;
            r_init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (w_wgrant)      r_state <= S_WR_ACK;
          else if (w_rgrant) r_state <= S_RD_WAIT;
        end
        S_WR_ACK:  r_state <= S_IDLE;
        S_RD_WAIT: begin
          r_dbg_rdata <= i_rdata;
          r_state     <= S_RD_ACK;
        end
        S_RD_ACK:  r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

endmodule
